// File: rtl/wb4_to_pi1_pkg.sv
// Shared definitions for the Wishbone B4 pipelined slave to PI1 master bridge:
// PI1 opcodes and a constant-evaluable ceiling log2.
package wb4_to_pi1_pkg;

  localparam logic [1:0] PINOOP = 2'b00;
  localparam logic [1:0] PIWROP = 2'b01;
  localparam logic [1:0] PIRDOP = 2'b10;
  localparam logic [1:0] PIRWOP = 2'b11;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/wb4_to_pi1_fifo.sv
// Small synchronous request FIFO: registered storage, combinational head read,
// flush empties it in one edge. Pointers wrap naturally.
module wb4_to_pi1_fifo
  import wb4_to_pi1_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTRW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTRW-1:0]  wr_ptr;
  logic [PTRW-1:0]  rd_ptr;
  logic [PTRW:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTRW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb4_to_pi1.sv
// Wishbone B4 pipelined slave to PI1 master bridge. Requests are queued in a
// small FIFO, issued one at a time on PI1, and acked in order with read data.
module wb4_to_pi1
  import wb4_to_pi1_pkg::*;
#(
  parameter int  ARCHBITSZ = 32,
  parameter int  REQDEPTH  = 2,
  localparam int ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ / 8)
) (
  input  logic                   wb4_clk_i,
  input  logic                   wb4_rst_i,
  input  logic                   wb4_cyc_i,
  input  logic                   wb4_stb_i,
  input  logic                   wb4_we_i,
  input  logic [ARCHBITSZ-1:0]   wb4_addr_i,
  input  logic [ARCHBITSZ-1:0]   wb4_data_i,
  input  logic [ARCHBITSZ/8-1:0] wb4_sel_i,
  output logic                   wb4_stall_o,
  output logic                   wb4_ack_o,
  output logic [ARCHBITSZ-1:0]   wb4_data_o,
  output logic [1:0]             pi1_op_o,
  output logic [ADDRBITSZ-1:0]   pi1_addr_o,
  output logic [ARCHBITSZ-1:0]   pi1_data_o,
  output logic [ARCHBITSZ/8-1:0] pi1_sel_o,
  input  logic [ARCHBITSZ-1:0]   pi1_data_i,
  input  logic                   pi1_rdy_i
);

  localparam int SELBITSZ = ARCHBITSZ / 8;
  localparam int OFFBITS  = clog2(SELBITSZ);
  localparam int ENTRYW   = 1 + ADDRBITSZ + ARCHBITSZ + SELBITSZ;

  logic              push;
  logic              flush;
  logic              full;
  logic              empty;
  logic [ENTRYW-1:0] wdata;
  logic [ENTRYW-1:0] head;
  logic              head_we;
  logic              accept;
  logic              complete;
  logic              inflight;
  logic              inflight_we;
  logic              discard;
  logic              unused_offset;

  // Handshakes: a wishbone request transfers on an edge with cyc&stb&!stall;
  // a PI1 op transfers on an edge with rdy=1 and op!=NOOP, and the next rdy=1
  // edge after that completes it.
  assign push        = wb4_cyc_i & wb4_stb_i & ~full;
  assign flush       = ~wb4_cyc_i;
  assign accept      = pi1_rdy_i & ~empty;
  assign complete    = pi1_rdy_i & inflight;
  assign wb4_stall_o = full;

  assign wdata = {wb4_we_i, wb4_addr_i[ARCHBITSZ-1:OFFBITS], wb4_data_i, wb4_sel_i};
  assign head_we = head[ENTRYW-1];
  assign unused_offset = ^wb4_addr_i[OFFBITS-1:0];

  wb4_to_pi1_fifo #(
    .WIDTH(ENTRYW),
    .DEPTH(REQDEPTH)
  ) u_fifo (
    .clk  (wb4_clk_i),
    .rst  (wb4_rst_i),
    .push (push),
    .pop  (accept),
    .flush(flush),
    .wdata(wdata),
    .head (head),
    .full (full),
    .empty(empty)
  );

  // Stale FIFO storage is masked so an idle bus shows all-zero fields.
  always_comb begin
    pi1_op_o   = PINOOP;
    pi1_addr_o = '0;
    pi1_data_o = '0;
    pi1_sel_o  = '0;
    if (!empty) begin
      pi1_op_o   = head_we ? PIWROP : PIRDOP;
      pi1_addr_o = head[ENTRYW-2 -: ADDRBITSZ];
      pi1_data_o = head[SELBITSZ +: ARCHBITSZ];
      pi1_sel_o  = head[SELBITSZ-1:0];
    end
  end

  always_ff @(posedge wb4_clk_i) begin
    if (wb4_rst_i) begin
      inflight    <= 1'b0;
      inflight_we <= 1'b0;
      discard     <= 1'b0;
      wb4_ack_o   <= 1'b0;
      wb4_data_o  <= '0;
    end else begin
      wb4_ack_o <= complete & ~discard;
      if (complete) wb4_data_o <= inflight_we ? '0 : pi1_data_i;

      if (accept) begin
        inflight    <= 1'b1;
        inflight_we <= head_we;
      end else if (complete) begin
        inflight <= 1'b0;
      end

      // Dropping cyc orphans whatever op is on PI1 after this edge; its
      // completion must not ack into a later cycle.
      if (!wb4_cyc_i) discard <= accept | (inflight & ~complete);
      else if (complete) discard <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb4_to_pi1.sv
// Bench for wb4_to_pi1: table-driven request vectors plus hand sequences for
// latency, stall, cyc drop and reset, with an in-order ack scoreboard.
module tb_wb4_to_pi1;
  import wb4_to_pi1_pkg::*;

  logic        clk;
  logic        rst;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic        stall;
  logic        ack;
  logic [31:0] rdat;
  logic [1:0]  pi_op;
  logic [29:0] pi_addr;
  logic [31:0] pi_wdat;
  logic [3:0]  pi_sel;
  logic [31:0] pi_rdat;
  logic        pi_rdy;

  logic [31:0] exp_q[$];
  int n_tests;
  int n_fail;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic [1:0]  exp_op;
    logic [29:0] exp_paddr;
  } vec_t;

  vec_t vecs[8];

  wb4_to_pi1 #(.ARCHBITSZ(32), .REQDEPTH(2)) dut (
    .wb4_clk_i  (clk),
    .wb4_rst_i  (rst),
    .wb4_cyc_i  (cyc),
    .wb4_stb_i  (stb),
    .wb4_we_i   (we),
    .wb4_addr_i (addr),
    .wb4_data_i (wdat),
    .wb4_sel_i  (sel),
    .wb4_stall_o(stall),
    .wb4_ack_o  (ack),
    .wb4_data_o (rdat),
    .pi1_op_o   (pi_op),
    .pi1_addr_o (pi_addr),
    .pi1_data_o (pi_wdat),
    .pi1_sel_o  (pi_sel),
    .pi1_data_i (pi_rdat),
    .pi1_rdy_i  (pi_rdy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- slave model ----------------
  function automatic logic [31:0] slave_data(input logic [29:0] a);
    if (a == 30'h41) return 32'hDEADBEEF;
    return {2'b10, a} ^ 32'h5A5A_0000;
  endfunction

  // ---------------- checks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: scoreboard push on wishbone accept, slave data update on PI1
  // accept, scoreboard pop/compare on ack. Leaves us #1 after the edge.
  task automatic step();
    logic        acc;
    logic        pi_acc;
    logic [31:0] nxt;
    acc    = !rst && cyc && stb && !stall;
    pi_acc = pi_rdy && (pi_op != PINOOP);
    nxt    = slave_data(pi_addr);
    if (acc) exp_q.push_back(we ? 32'h0 : slave_data(addr[31:2]));
    @(posedge clk);
    #1;
    if (pi_acc) pi_rdat = nxt;
    if (ack) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL ack_unexpected: got ack with data %0h expected no ack", rdat);
      end else begin
        chk("ack_data", rdat, exp_q.pop_front());
      end
    end
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() > 0 && b < 50) begin
      step();
      b++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic drive_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    cyc  = 1'b1;
    stb  = 1'b1;
    we   = w;
    addr = a;
    wdat = d;
    sel  = s;
  endtask

  task automatic wait_accept();
    int  b;
    logic acc;
    b = 0;
    acc = 1'b0;
    while (!acc && b < 20) begin
      acc = cyc && stb && !stall;
      step();
      b++;
    end
    chk("accept_timeout", acc, 1'b1);
  endtask

  // ---------------- test ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    addr = '0; wdat = '0; sel = '0; pi_rdat = '0; pi_rdy = 1'b1;

    for (int i = 0; i < 4; i++) begin
      vecs[i].we        = 1'b1;
      vecs[i].addr      = 32'h10 + 32'(4 * i);
      vecs[i].data      = 32'(i + 1);
      vecs[i].sel       = 4'hF;
      vecs[i].exp_op    = PIWROP;
      vecs[i].exp_paddr = 30'(4 + i);
    end
    for (int i = 4; i < 8; i++) begin
      vecs[i].we        = 1'b0;
      vecs[i].addr      = 32'($urandom_range(0, 32'hFFFF));
      vecs[i].data      = $urandom;
      vecs[i].sel       = 4'($urandom_range(1, 15));
      vecs[i].exp_op    = PIRDOP;
      vecs[i].exp_paddr = vecs[i].addr[31:2];
    end

    step();
    step();
    rst = 1'b0;
    chk("rst_ack", ack, 1'b0);
    chk("rst_rdata", rdat, 32'h0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_op", pi_op, PINOOP);
    chk("rst_paddr", pi_addr, 30'h0);
    chk("rst_pdata", pi_wdat, 32'h0);
    chk("rst_psel", pi_sel, 4'h0);

    // single read latency
    drive_req(1'b0, 32'h104, 32'h0, 4'hF);
    step();
    stb = 1'b0;
    chk("lat_op", pi_op, PIRDOP);
    chk("lat_paddr", pi_addr, 30'h41);
    chk("lat_psel", pi_sel, 4'hF);
    step();
    chk("lat_noack_c2", ack, 1'b0);
    step();
    chk("lat_ack_c3", ack, 1'b1);
    chk("lat_data_c3", rdat, 32'hDEADBEEF);
    step();
    chk("lat_pulse", ack, 1'b0);
    drain();

    // back-to-back table vectors, rdy always high
    for (int i = 0; i < 8; i++) begin
      drive_req(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].sel);
      chk("vec_stall", stall, 1'b0);
      step();
      chk("vec_op", pi_op, vecs[i].exp_op);
      chk("vec_paddr", pi_addr, vecs[i].exp_paddr);
      chk("vec_pdata", pi_wdat, vecs[i].data);
      chk("vec_psel", pi_sel, vecs[i].sel);
    end
    stb = 1'b0;
    drain();

    // stall with rdy low for 5 edges, 3 reads queued against depth 2
    pi_rdy = 1'b0;
    drive_req(1'b0, 32'h200, 32'h0, 4'hF);
    chk("stall_r1", stall, 1'b0);
    step();
    drive_req(1'b0, 32'h204, 32'h0, 4'h3);
    chk("stall_r2", stall, 1'b0);
    step();
    drive_req(1'b0, 32'h208, 32'h0, 4'hC);
    for (int i = 0; i < 3; i++) begin
      chk("stall_r3", stall, 1'b1);
      chk("hold_op", pi_op, PIRDOP);
      chk("hold_paddr", pi_addr, 30'h80);
      chk("hold_psel", pi_sel, 4'hF);
      chk("hold_noack", ack, 1'b0);
      step();
    end
    pi_rdy = 1'b1;
    wait_accept();
    stb = 1'b0;
    drain();

    // cyc dropped with first read in flight and second queued
    drive_req(1'b0, 32'h300, 32'h0, 4'hF);
    step();
    drive_req(1'b0, 32'h304, 32'h0, 4'hF);
    step();
    cyc = 1'b0; stb = 1'b0; pi_rdy = 1'b0;
    exp_q.delete();
    step();
    chk("drop_op", pi_op, PINOOP);
    chk("drop_stall", stall, 1'b0);
    chk("drop_ack", ack, 1'b0);
    step();
    chk("drop_ack2", ack, 1'b0);
    pi_rdy = 1'b1;
    step();
    chk("drop_ack3", ack, 1'b0);
    step();
    chk("drop_ack4", ack, 1'b0);
    chk("drop_op2", pi_op, PINOOP);
    drive_req(1'b0, 32'h308, 32'h0, 4'hF);
    step();
    stb = 1'b0;
    drain();

    // reset with an op in flight and rdy low
    drive_req(1'b0, 32'h400, 32'h0, 4'hF);
    step();
    drive_req(1'b0, 32'h404, 32'h0, 4'hF);
    step();
    pi_rdy = 1'b0; stb = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    chk("mrst_op", pi_op, PINOOP);
    chk("mrst_ack", ack, 1'b0);
    chk("mrst_stall", stall, 1'b0);
    chk("mrst_paddr", pi_addr, 30'h0);
    chk("mrst_rdata", rdat, 32'h0);
    pi_rdy = 1'b1;
    step();
    chk("mrst_ack2", ack, 1'b0);
    step();
    chk("mrst_ack3", ack, 1'b0);
    drive_req(1'b0, 32'h408, 32'h0, 4'hF);
    step();
    stb = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
